// File: rtl/risc_v_mem_bridge.sv
// Bridge between a stalling RISC-V core port and a ready/valid word memory.
// Misaligned or timed-out accesses end in a one-cycle error pulse.
module risc_v_mem_bridge #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_adr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        core_err,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [29:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // state   | meaning
    // IDLE    | waiting for a core request
    // ISSUE   | mem_valid asserted, waiting for mem_ready
    // WAIT_RD | read accepted, waiting for mem_rvalid
    // DONE    | one-cycle completion, core released
    // ERR     | one-cycle error pulse (misaligned or timeout)
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, DONE, ERR} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic        req_we;
    logic [29:0] req_adr;
    logic [31:0] req_wdata;
    logic [7:0]  cnt;
    logic        expired;

    // cnt holds the number of busy cycles already spent before this one
    assign expired    = (cnt >= CNT_LAST);
    assign mem_adr    = req_adr;
    assign mem_wdata  = req_wdata;
    assign core_stall = (state == ISSUE) || (state == WAIT_RD) ||
                        ((state == IDLE) && core_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_we     <= 1'b0;
            req_adr    <= '0;
            req_wdata  <= '0;
            cnt        <= '0;
            core_rdata <= '0;
            core_err   <= 1'b0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            core_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req) begin
                        if (core_adr[1:0] == 2'b00) begin
                            req_we    <= core_we;
                            req_adr   <= core_adr[31:2];
                            req_wdata <= core_wdata;
                            cnt       <= '0;
                            mem_valid <= 1'b1;
                            mem_we    <= core_we;
                            state     <= ISSUE;
                        end else begin
                            core_err <= 1'b1;
                            state    <= ERR;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        if (req_we) begin
                            state <= DONE;
                        end else if (mem_rvalid) begin
                            core_rdata <= mem_rdata;
                            state      <= DONE;
                        end else begin
                            cnt   <= cnt + 8'd1;
                            state <= WAIT_RD;
                        end
                    end else if (expired) begin
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        core_err  <= 1'b1;
                        state     <= ERR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_RD: begin
                    if (mem_rvalid) begin
                        core_rdata <= mem_rdata;
                        state      <= DONE;
                    end else if (expired) begin
                        core_err <= 1'b1;
                        state    <= ERR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_v_mem_bridge.sv
// Directed bench for risc_v_mem_bridge: a vector table of whole transactions
// plus hand sequences for reset, stray rvalid and back-to-back requests.
module tb_risc_v_mem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [31:0] core_adr = '0;
    logic [31:0] core_wdata = '0;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        core_err;
    logic        mem_valid;
    logic        mem_we;
    logic [29:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    risc_v_mem_bridge #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_adr(core_adr),
        .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_stall(core_stall), .core_err(core_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // r / v: busy cycle (1 = first ISSUE) on which mem_ready / mem_rvalid pulse, 0 = never
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          r;
        int          v;
        int          exp_err;
        int          exp_stall;
        int          exp_valid;
        int          exp_wecnt;
        logic [29:0] exp_adr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t tv);
        int stall_cnt = 0;
        int valid_cnt = 0;
        int we_cnt = 0;
        int err_cnt = 0;
        int bad_bus = 0;
        bit done = 1'b0;
        logic [31:0] fin_rdata = '0;
        string tag;
        tag = $sformatf("v%0d", idx);
        core_req   = 1'b1;
        core_we    = tv.we;
        core_adr   = tv.adr;
        core_wdata = tv.wdata;
        mem_rdata  = tv.rdata;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_ready  = (tv.r != 0) && (c == tv.r);
            mem_rvalid = (tv.v != 0) && (c == tv.v);
            #1;
            if (core_stall) stall_cnt++;
            if (core_err) err_cnt++;
            if (mem_valid) begin
                valid_cnt++;
                if (mem_we) we_cnt++;
                if (mem_adr !== tv.exp_adr) bad_bus++;
                if (tv.we && mem_wdata !== tv.wdata) bad_bus++;
            end
            if (c >= 1 && !core_stall) begin
                done = 1'b1;
                fin_rdata = core_rdata;
            end
            tick();
        end
        core_req   = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        if (core_err) err_cnt++;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err_cycles"}, 32'(err_cnt), 32'(tv.exp_err));
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(tv.exp_stall));
        check({tag, "_valid_cycles"}, 32'(valid_cnt), 32'(tv.exp_valid));
        check({tag, "_we_cycles"}, 32'(we_cnt), 32'(tv.exp_wecnt));
        check({tag, "_bus_unstable"}, 32'(bad_bus), 32'd0);
        check({tag, "_rdata_final"}, fin_rdata, tv.exp_rdata);
        check({tag, "_rdata_after"}, core_rdata, tv.exp_rdata);
        tick();
    endtask

    initial begin
        //          we    adr            wdata          rdata          r  v  err stall valid wecnt adr            exp_rdata
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1, 1, 0, 2,  1,  0, 30'h4,          32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,         4, 0, 0, 5,  4,  4, 30'h8,          32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h0000_0013, 32'h0,         32'h0BAD_0BAD, 1, 1, 1, 1,  0,  0, 30'h4,          32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         32'h0BAD_0BAD, 0, 0, 1, 16, 15, 0, 30'h10,         32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 32'h0000_0044, 32'h0,         32'hCAFE_F00D, 1, 15, 0, 16, 1, 0, 30'h11,         32'hCAFE_F00D};
        vecs[5] = '{1'b0, 32'h0000_0048, 32'h0,         32'hA5A5_0001, 2, 4, 0, 5,  2,  0, 30'h12,         32'hA5A5_0001};
        vecs[6] = '{1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0,         1, 0, 1, 1,  0,  0, 30'h0,          32'hA5A5_0001};
        vecs[7] = '{1'b0, 32'h0000_004C, 32'h0,         32'h0BAD_0BAD, 1, 0, 1, 16, 1,  0, 30'h13,         32'hA5A5_0001};
        vecs[8] = '{1'b1, 32'hFFFF_FFFC, 32'h0BAD_C0DE, 32'h0,         1, 0, 0, 2,  1,  1, 30'h3FFF_FFFF,  32'hA5A5_0001};
        vecs[9] = '{1'b0, 32'h0000_0100, 32'h0,         32'h1111_2222, 1, 3, 0, 4,  1,  0, 30'h40,         32'h1111_2222};

        // reset state
        #12;
        check("rst_rdata", core_rdata, 32'h0);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_err", 32'(core_err), 32'd0);
        check("rst_adr", 32'(mem_adr), 32'd0);
        check("rst_stall", 32'(core_stall), 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // stray rvalid while idle is ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h9999_9999;
        tick();
        tick();
        mem_rvalid = 1'b0;
        check("stray_rvalid_rdata", core_rdata, 32'h1111_2222);
        check("stray_rvalid_valid", 32'(mem_valid), 32'd0);

        // async reset in the middle of WAIT_RD
        core_req = 1'b1; core_we = 1'b0; core_adr = 32'h0000_0080;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        check("wait_rd_valid_low", 32'(mem_valid), 32'd0);
        check("wait_rd_stall", 32'(core_stall), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_rdata", core_rdata, 32'h0);
        check("async_rst_adr", 32'(mem_adr), 32'd0);
        check("async_rst_valid", 32'(mem_valid), 32'd0);
        core_req   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick();
        #3;
        rst = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("late_rvalid_rdata", core_rdata, 32'h0);
        check("late_rvalid_stall", 32'(core_stall), 32'd0);

        // first request accepted on the first edge after reset release
        #3;
        rst = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_adr = 32'h0000_0100;
        #2;
        rst = 1'b1;
        tick();
        check("post_rst_issue_valid", 32'(mem_valid), 32'd1);
        check("post_rst_issue_adr", 32'(mem_adr), 32'h40);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b0; core_req = 1'b0;
        #1;
        check("post_rst_done_rdata", core_rdata, 32'h5555_AAAA);
        check("post_rst_done_stall", 32'(core_stall), 32'd0);
        tick();

        // back-to-back reads with request held
        core_req = 1'b1; core_we = 1'b0; core_adr = 32'h0000_0000;
        tick();
        check("b2b_issue1_adr", 32'(mem_adr), 32'h0);
        check("b2b_issue1_valid", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_00A0;
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        core_adr = 32'h0000_0004;
        #1;
        check("b2b_done1_rdata", core_rdata, 32'h0000_00A0);
        check("b2b_done1_stall", 32'(core_stall), 32'd0);
        tick();
        check("b2b_idle_valid", 32'(mem_valid), 32'd0);
        check("b2b_idle_stall", 32'(core_stall), 32'd1);
        tick();
        check("b2b_issue2_valid", 32'(mem_valid), 32'd1);
        check("b2b_issue2_adr", 32'(mem_adr), 32'h1);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_00B4;
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b0; core_req = 1'b0;
        #1;
        check("b2b_done2_rdata", core_rdata, 32'h0000_00B4);
        check("b2b_done2_err", 32'(core_err), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
